// File: rtl/div_unit.sv
// Purpose : radix-2 restoring divider for DIV/DIVU; quotient -> lo, remainder -> hi.
// Latency : DATA_W+1 cycles from the accepting edge to valid (2 cycles for a zero divisor).
// Backpressure: none; busy stalls the pipeline, start is ignored while busy, cancel aborts.
//
// Ports:
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   start, signed_div    request and DIV/DIVU select, sampled only on the accepting edge
//   cancel               flush; wins over start in every state
//   a, b                 dividend, divisor
//   busy, valid          busy while calculating; valid is a one-cycle result pulse
//   lo, hi, div_by_zero  quotient, remainder, zero-divisor flag (held until next result)
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              signed_div,
    input  logic              cancel,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              valid,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi,
    output logic              div_by_zero
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  rem_q, rem_d;     // partial remainder
    logic [DATA_W-1:0]  quo_q, quo_d;     // dividend shifts out of the top, quotient bits shift in
    logic [DATA_W-1:0]  dsr_q, dsr_d;     // divisor magnitude
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic               zdiv_q, zdiv_d;   // zero divisor: skip the iterations
    logic [DATA_W-1:0]  lo_q, lo_d;
    logic [DATA_W-1:0]  hi_q, hi_d;
    logic               dbz_q, dbz_d;

    logic               sa, sb;
    logic [DATA_W-1:0]  abs_a, abs_b;
    logic [DATA_W:0]    shifted;
    logic [DATA_W+1:0]  trial;
    logic               fits;
    logic [DATA_W-1:0]  rem_step, quo_step;
    logic [DATA_W-1:0]  q_fix, r_fix;

    // Datapath for one iteration and the operand/result sign handling.
    always_comb begin
        sa    = signed_div & a[DATA_W-1];
        sb    = signed_div & b[DATA_W-1];
        // The most negative value maps onto itself, which is its correct unsigned magnitude.
        abs_a = sa ? ({DATA_W{1'b0}} - a) : a;
        abs_b = sb ? ({DATA_W{1'b0}} - b) : b;

        shifted  = {rem_q, quo_q[DATA_W-1]};
        trial    = {1'b0, shifted} - {2'b00, dsr_q};
        fits     = ~trial[DATA_W+1];
        // When the subtraction fits, the difference is below the divisor and so fits in DATA_W bits;
        // when it does not, the shifted value is below the divisor, so its top bit is clear.
        rem_step = fits ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
        quo_step = {quo_q[DATA_W-2:0], fits};

        q_fix    = q_neg_q ? ({DATA_W{1'b0}} - quo_step) : quo_step;
        r_fix    = r_neg_q ? ({DATA_W{1'b0}} - rem_step) : rem_step;
    end

    // Next-state and register updates.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        zdiv_d  = zdiv_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        dbz_d   = dbz_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d = ST_CALC;
                    rem_d   = '0;
                    // A zero divisor reports the raw dividend as remainder, so keep it unmodified.
                    quo_d   = (b == '0) ? a : abs_a;
                    dsr_d   = abs_b;
                    cnt_d   = '0;
                    q_neg_d = sa ^ sb;
                    r_neg_d = sa;
                    zdiv_d  = (b == '0);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else if (zdiv_q) begin
                    state_d = ST_DONE;
                    lo_d    = '1;
                    hi_d    = quo_q;
                    dbz_d   = 1'b1;
                end else begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = ST_DONE;
                        lo_d    = q_fix;
                        hi_d    = r_fix;
                        dbz_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            cnt_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            zdiv_q  <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            zdiv_q  <= zdiv_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == ST_CALC);
    assign valid       = (state_q == ST_DONE);
    assign lo          = lo_q;
    assign hi          = hi_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_unit.sv
// Purpose : checks div_unit against an arithmetic reference model plus directed literal expectations.
// Latency : model expects valid 33 cycles after acceptance (2 for a zero divisor).
// Backpressure: start is driven freely; the model ignores it while an op is in flight.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic        cancel = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, valid, div_by_zero;
    logic [31:0] lo, hi;

    int n_chk  = 0;
    int n_pass = 0;

    div_unit #(.DATA_W(32)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .signed_div  (signed_div),
        .cancel      (cancel),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .valid       (valid),
        .lo          (lo),
        .hi          (hi),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    endtask

    // Reference arithmetic: what DIV/DIVU must return for one operand pair.
    function automatic void model_div(input logic [31:0] x, input logic [31:0] y, input logic sg,
                                      output logic [31:0] q, output logic [31:0] r, output logic z);
        if (y == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = x;
            z = 1'b1;
        end else if (sg) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
            end
            z = 1'b0;
        end else begin
            q = x / y;
            r = x % y;
            z = 1'b0;
        end
    endfunction

    // Model: an op in flight finishes a fixed number of edges after acceptance.
    int          m_left = 0;
    logic        m_valid = 1'b0;
    logic [31:0] m_lo = '0, m_hi = '0;
    logic        m_dbz = 1'b0;
    logic [31:0] p_lo = '0, p_hi = '0;
    logic        p_dbz = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (!resetn) begin
                m_left = 0; m_valid = 1'b0; m_lo = '0; m_hi = '0; m_dbz = 1'b0;
            end else begin
                m_valid = 1'b0;
                if (m_left > 0) begin
                    if (cancel) m_left = 0;
                    else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_valid = 1'b1; m_lo = p_lo; m_hi = p_hi; m_dbz = p_dbz;
                        end
                    end
                end else if (start && !cancel) begin
                    model_div(a, b, signed_div, p_lo, p_hi, p_dbz);
                    m_left = (b == 32'd0) ? 1 : 32;
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_valid", {31'd0, valid}, 32'd0);
                chk("rst_lo", lo, 32'd0);
                chk("rst_hi", hi, 32'd0);
                chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
            end else begin
                chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
                chk("valid", {31'd0, valid}, {31'd0, m_valid});
                chk("lo", lo, m_lo);
                chk("hi", hi, m_hi);
                chk("dbz", {31'd0, div_by_zero}, {31'd0, m_dbz});
            end
        end
    end

    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic sg,
                         output int lat, output int bcnt);
        @(negedge clk);
        a = x; b = y; signed_div = sg; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; bcnt = 0;
        while (!valid && lat < 100) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        case ($urandom_range(0, 15))
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3, 4:    v = $urandom_range(1, 16);
            5:       v = 32'd0 - $urandom_range(1, 16);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int lat, bc, vcnt;
        logic [31:0] mq, mr;
        logic mz;

        // Pin the reference model itself.
        model_div(32'd100, 32'd7, 1'b0, mq, mr, mz);
        chk("model_divu_q", mq, 32'd14);
        chk("model_divu_r", mr, 32'd2);
        model_div(32'hFFFF_FFF9, 32'd2, 1'b1, mq, mr, mz);
        chk("model_div_q", mq, 32'hFFFF_FFFD);
        chk("model_div_r", mr, 32'hFFFF_FFFF);

        repeat (3) @(negedge clk);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        resetn = 1'b1;

        // Basic unsigned op, latency and busy length.
        do_op(32'd100, 32'd7, 1'b0, lat, bc);
        chk("t1_lat", lat, 32'd33);
        chk("t1_busy_cycles", bc, 32'd32);
        chk("t1_lo", lo, 32'd14);
        chk("t1_hi", hi, 32'd2);
        @(negedge clk);
        chk("t1_single_pulse", {31'd0, valid}, 32'd0);

        // Signed cases and a full-range unsigned dividend.
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, lat, bc);
        chk("t2a_lo", lo, 32'hFFFF_FFFD);
        chk("t2a_hi", hi, 32'hFFFF_FFFF);
        do_op(32'd7, 32'hFFFF_FFFE, 1'b1, lat, bc);
        chk("t2b_lo", lo, 32'hFFFF_FFFD);
        chk("t2b_hi", hi, 32'd1);
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, lat, bc);
        chk("t2c_lo", lo, 32'hFFFF_FFFF);
        chk("t2c_hi", hi, 32'd0);

        // Signed overflow.
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, bc);
        chk("t3_lo", lo, 32'h8000_0000);
        chk("t3_hi", hi, 32'd0);
        chk("t3_dbz", {31'd0, div_by_zero}, 32'd0);

        // Divide by zero, then a good op clears the flag.
        do_op(32'h0000_1234, 32'd0, 1'b0, lat, bc);
        chk("t4_lat", lat, 32'd2);
        chk("t4_lo", lo, 32'hFFFF_FFFF);
        chk("t4_hi", hi, 32'h0000_1234);
        chk("t4_dbz", {31'd0, div_by_zero}, 32'd1);
        do_op(32'hFFFF_FFF0, 32'd0, 1'b1, lat, bc);
        chk("t4_signed_hi_raw", hi, 32'hFFFF_FFF0);
        do_op(32'd100, 32'd7, 1'b0, lat, bc);
        chk("t4_dbz_cleared", {31'd0, div_by_zero}, 32'd0);

        // Cancel after 10 iterations.
        @(negedge clk);
        a = 32'd1000; b = 32'd3; signed_div = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("t5_busy_after_cancel", {31'd0, busy}, 32'd0);
        chk("t5_lo_kept", lo, 32'd14);
        chk("t5_hi_kept", hi, 32'd2);
        vcnt = 0;
        repeat (40) begin @(negedge clk); if (valid) vcnt++; end
        chk("t5_no_valid", vcnt, 32'd0);
        do_op(32'd1000, 32'd3, 1'b0, lat, bc);
        chk("t5_lat", lat, 32'd33);
        chk("t5_lo", lo, 32'd333);
        chk("t5_hi", hi, 32'd1);

        // start together with cancel in IDLE is not accepted.
        @(negedge clk);
        a = 32'd5; b = 32'd1; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        chk("t5_start_cancel_busy", {31'd0, busy}, 32'd0);
        vcnt = 0;
        repeat (40) begin @(negedge clk); if (valid) vcnt++; end
        chk("t5_start_cancel_no_valid", vcnt, 32'd0);

        // Asynchronous reset in the middle of a calculation.
        @(negedge clk);
        a = 32'd99; b = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_lo", lo, 32'd0);
        chk("t6_rst_hi", hi, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Back-to-back: second start issued during the DONE cycle.
        do_op(32'd50, 32'd5, 1'b0, lat, bc);
        chk("t6_first_lo", lo, 32'd10);
        chk("t6_first_hi", hi, 32'd0);
        a = 32'd81; b = 32'd9; signed_div = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!valid && lat < 100) begin @(negedge clk); lat++; end
        chk("t6_b2b_lat", lat, 32'd33);
        chk("t6_b2b_lo", lo, 32'd9);
        chk("t6_b2b_hi", hi, 32'd0);
        @(negedge clk);
        chk("t6_b2b_single_pulse", {31'd0, valid}, 32'd0);

        // Random traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 30000; i++) begin
            @(negedge clk);
            start      = ($urandom_range(0, 3) != 0);
            cancel     = ($urandom_range(0, 99) == 0);
            signed_div = $urandom_range(0, 1) == 1;
            a          = rand_operand();
            b          = rand_operand();
        end
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
